// File: rtl/ram8_pkg.sv
// Shared sizing and types for the RAM hierarchy (ram8, and later ram64/ram512).
// The word type and the one-hot write decode are reused by the larger blocks.
package ram8_pkg;
  localparam int WIDTH  = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef logic [WIDTH-1:0]  word_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DEPTH-1:0]  sel_t;

  // At most one word enabled: the addressed one, and only when load is high.
  function automatic sel_t decode_load(input logic load, input addr_t address);
    sel_t sel;
    sel          = '0;
    sel[address] = load;
    return sel;
  endfunction
endpackage

// File: rtl/word_reg.sv
// One WIDTH-bit word built from per-bit D flip-flops, each with a load mux in front.
// Synchronous reset clears the word and takes priority over load.
module word_reg
  import ram8_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  word_t in,
  input  logic  load,
  output word_t out
);

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic q;

    always_ff @(posedge clk) begin
      if (reset) begin
        q <= 1'b0;
      end else if (load) begin
        q <= in[b];
      end
    end

    assign out[b] = q;
  end

endmodule

// File: rtl/ram8.sv
// Eight-word RAM: one-hot write decode, eight word registers, combinational 8:1 read mux.
// Reads have no clock involvement; there is no write-through bypass.
module ram8
  import ram8_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  word_t in,
  input  logic  load,
  input  addr_t address,
  output word_t out
);

  sel_t  word_load;
  word_t words [DEPTH];

  always_comb begin
    word_load = decode_load(load, address);
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    word_reg u_word (
      .clk   (clk),
      .reset (reset),
      .in    (in),
      .load  (word_load[i]),
      .out   (words[i])
    );
  end

  // Read path follows address immediately; a same-cycle write shows only after the edge.
  always_comb begin
    out = words[address];
  end

endmodule
